lfsr_scrambler_gen: RTL and testbench

Parametrised LFSR scrambler/descrambler for the serial datapath, successor to the fixed 15-bit scrambler. Generalises register length, feedback polynomial and bits processed per cycle, and adds run-time selectable additive, self-synchronising scramble and self-synchronising descramble modes. Also adds a valid/ready stream interface, seed loading, period detection and all-zero lock-up protection. Sits between the framer and the line encoder; one instance per lane.

---
 rtl/lfsr_scrambler_gen_pkg.sv | 24 ++
 rtl/lfsr_scrambler_gen_if.sv | 21 ++
 rtl/lfsr_scrambler_gen_step.sv | 38 +++
 rtl/lfsr_scrambler_gen.sv | 97 +++++++++
 tb/tb_lfsr_scrambler_gen.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_scrambler_gen_pkg.sv
// Shared definitions for the LFSR scrambler: mode encoding and PRBS15 defaults.
package lfsr_scrambler_gen_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_MSCR = 2'd1,
    MODE_MDSC = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam int          PRBS15_WIDTH = 15;
  localparam logic [14:0] PRBS15_POLY  = 15'h6000;
  localparam logic [14:0] PRBS15_SEED  = 15'h00A9;

  // The reserved encoding behaves exactly like additive mode.
  function automatic mode_e norm_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_MSCR;
      2'd2:    return MODE_MDSC;
      default: return MODE_ADD;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_scrambler_gen_if.sv
// Valid/ready stream bundle between framer, scrambler and line encoder.
interface lfsr_scrambler_gen_if #(
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] din;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] dout;

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout
  );

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout
  );
endinterface

// File: rtl/lfsr_scrambler_gen_step.sv
// Combinational LFSR advance over DATA_W bits, bit 0 first.
module lfsr_scrambler_gen_step
  import lfsr_scrambler_gen_pkg::*;
#(
  parameter int               WIDTH  = 15,
  parameter logic [WIDTH-1:0] POLY   = 15'h6000,
  parameter int               DATA_W = 8
) (
  input  logic [WIDTH-1:0]  state,
  input  logic [DATA_W-1:0] din,
  input  mode_e             mode,
  output logic [WIDTH-1:0]  state_next,
  output logic [DATA_W-1:0] dout
);

  // Unrolled per-bit feedback; the shifted-in bit depends on the mode.
  always_comb begin
    logic [WIDTH-1:0] s;
    logic             f;
    logic             s_in;
    s    = state;
    f    = 1'b0;
    s_in = 1'b0;
    dout = '0;
    for (int i = 0; i < DATA_W; i++) begin
      f       = ^(s & POLY);
      dout[i] = din[i] ^ f;
      case (mode)
        MODE_MSCR: s_in = dout[i];
        MODE_MDSC: s_in = din[i];
        default:   s_in = f;
      endcase
      s = {s[WIDTH-2:0], s_in};
    end
    state_next = s;
  end

endmodule

// File: rtl/lfsr_scrambler_gen.sv
// Per-lane LFSR scrambler/descrambler with stream handshake, seed load,
// period detection and zero-seed lock-up protection.
module lfsr_scrambler_gen
  import lfsr_scrambler_gen_pkg::*;
#(
  parameter int               WIDTH        = PRBS15_WIDTH,
  parameter logic [WIDTH-1:0] POLY         = WIDTH'(PRBS15_POLY),
  parameter int               DATA_W       = 8,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(PRBS15_SEED)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed,
  lfsr_scrambler_gen_if.slave  strm,
  output logic [WIDTH-1:0]     state_out,
  output logic                 period_pulse,
  output logic                 lockup_err
);

  logic [WIDTH-1:0]  state_q;
  logic [WIDTH-1:0]  seed_q;
  logic [WIDTH-1:0]  state_nxt;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_nxt;
  logic              out_valid_q;
  logic              accept;
  logic              zero_seed;
  mode_e             mode_q;
  mode_e             mode_in;

  assign mode_in   = norm_mode(mode);
  // An all-zero additive LFSR never leaves zero, so it is forced to 1.
  assign zero_seed = (seed == '0) && (mode_in == MODE_ADD);

  assign strm.in_ready  = !rst && !seed_load && (!out_valid_q || strm.out_ready);
  assign accept         = strm.in_valid && strm.in_ready;
  assign strm.out_valid = out_valid_q;
  assign strm.dout      = dout_q;
  assign state_out      = state_q;

  lfsr_scrambler_gen_step #(
    .WIDTH  (WIDTH),
    .POLY   (POLY),
    .DATA_W (DATA_W)
  ) u_step (
    .state      (state_q),
    .din        (strm.din),
    .mode       (mode_q),
    .state_next (state_nxt),
    .dout       (dout_nxt)
  );

  // LFSR state, stored seed and mode: loaded on seed_load, advanced on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED_DEFAULT;
      seed_q  <= SEED_DEFAULT;
      mode_q  <= MODE_ADD;
    end else if (seed_load) begin
      state_q <= zero_seed ? WIDTH'(1) : seed;
      seed_q  <= zero_seed ? WIDTH'(1) : seed;
      mode_q  <= mode_in;
    end else if (accept) begin
      state_q <= state_nxt;
    end
  end

  // Output register and period pulse; a held beat keeps dout stable.
  always_ff @(posedge clk) begin
    if (rst || seed_load) begin
      out_valid_q  <= 1'b0;
      dout_q       <= '0;
      period_pulse <= 1'b0;
    end else begin
      period_pulse <= 1'b0;
      if (accept) begin
        out_valid_q  <= 1'b1;
        dout_q       <= dout_nxt;
        period_pulse <= (mode_q == MODE_ADD) && (state_nxt == seed_q);
      end else if (strm.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Sticky lock-up flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lockup_err <= 1'b0;
    end else if (seed_load && zero_seed) begin
      lockup_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lfsr_scrambler_gen.sv
// Scoreboard bench: driver pushes model expectations, monitor pops on handshake.
module tb_lfsr_scrambler_gen;

  typedef bit hist_t[$];
  typedef struct {
    logic [7:0]  dout;
    logic [14:0] state;
    bit          chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        seed_load = 1'b0;
  logic [14:0] seed = '0;
  logic [14:0] state_out;
  logic        period_pulse;
  logic        lockup_err;

  logic [1:0]  p_mode = 2'd0;
  logic        p_seed_load = 1'b0;
  logic [14:0] p_seed = '0;
  logic [14:0] p_state;
  logic        p_pulse;
  logic        p_lock;

  int          vectors = 0;
  int          miscompares = 0;
  exp_t        exp_q[$];
  hist_t       hm;
  hist_t       hp;
  logic [1:0]  cur_mode = 2'd0;
  logic [14:0] poly_v = 15'h6000;
  bit          rdy_rand = 1'b0;
  bit          rdy_hold = 1'b1;
  logic [7:0]  orig[30];
  logic [7:0]  scr[30];

  lfsr_scrambler_gen_if #(.DATA_W(8)) bus ();
  lfsr_scrambler_gen_if #(.DATA_W(1)) bus1 ();

  always #5 clk = ~clk;

  lfsr_scrambler_gen #(
    .WIDTH(15), .POLY(15'h6000), .DATA_W(8), .SEED_DEFAULT(15'h00A9)
  ) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .seed_load(seed_load), .seed(seed),
    .strm(bus), .state_out(state_out), .period_pulse(period_pulse),
    .lockup_err(lockup_err)
  );

  lfsr_scrambler_gen #(
    .WIDTH(15), .POLY(15'h6000), .DATA_W(1), .SEED_DEFAULT(15'h00A9)
  ) u_per (
    .clk(clk), .rst(rst), .mode(p_mode), .seed_load(p_seed_load), .seed(p_seed),
    .strm(bus1), .state_out(p_state), .period_pulse(p_pulse),
    .lockup_err(p_lock)
  );

  // Reference model: the line sequence h obeys h[n] = g(x[n], XOR of taps
  // over the previous 15 line bits); the queue holds the most recent 15.
  function automatic void hist_seed(output hist_t h, input logic [14:0] s);
    h.delete();
    for (int k = 14; k >= 0; k--) h.push_back(s[k]);
  endfunction

  function automatic logic [14:0] hist_state(input hist_t h);
    logic [14:0] st;
    st = '0;
    for (int k = 0; k < 15; k++) st[k] = h[h.size()-1-k];
    return st;
  endfunction

  function automatic void model_step(inout hist_t h, input logic [14:0] poly,
                                     input logic [1:0] md, input int nb,
                                     input logic [7:0] d, output logic [7:0] o);
    bit f;
    bit nb_bit;
    o = '0;
    for (int i = 0; i < nb; i++) begin
      f = 1'b0;
      for (int k = 0; k < 15; k++)
        if (poly[k]) f = f ^ h[h.size()-1-k];
      o[i] = d[i] ^ f;
      if (md == 2'd1)      nb_bit = o[i];
      else if (md == 2'd2) nb_bit = d[i];
      else                 nb_bit = f;
      h.push_back(nb_bit);
      void'(h.pop_front());
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Downstream ready: random back-pressure or a held level.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
      else          bus.out_ready = rdy_hold;
    end
  end

  // Monitor: pop and compare on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && !seed_load && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got dout %0h expected no beat", bus.dout);
        end else begin
          e = exp_q.pop_front();
          if (e.chk) begin
            check("dout", bus.dout, e.dout);
            check("state_out", state_out, e.state);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit chk, input bit ovr,
                      input logic [7:0] od, output logic [7:0] mo);
    exp_t e;
    int   t;
    mo = '0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.din      = d;
    #1;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    model_step(hm, poly_v, cur_mode, 8, d, mo);
    e.dout  = ovr ? od : mo;
    e.state = hist_state(hm);
    e.chk   = chk;
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic load(input logic [14:0] s, input logic [1:0] m, input bit with_valid);
    logic [1:0] eff;
    @(negedge clk);
    seed_load    = 1'b1;
    seed         = s;
    mode         = m;
    bus.in_valid = with_valid;
    bus.din      = 8'h5A;
    #1;
    check("in_ready_on_load", bus.in_ready, 0);
    @(posedge clk);
    #1;
    seed_load    = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    eff = (m == 2'd3) ? 2'd0 : m;
    hist_seed(hm, (s == 15'd0 && eff == 2'd0) ? 15'd1 : s);
    cur_mode = eff;
    @(negedge clk);
    check("out_valid_after_load", bus.out_valid, 0);
  endtask

  task automatic do_reset(input int n, input bit valid_during);
    @(negedge clk);
    rst          = 1'b1;
    seed_load    = 1'b0;
    bus.in_valid = valid_during;
    bus.din      = 8'hFF;
    #1;
    check("in_ready_in_rst", bus.in_ready, 0);
    repeat (n) @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    hist_seed(hm, 15'h00A9);
    hist_seed(hp, 15'h00A9);
    cur_mode = 2'd0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_state", state_out, 15'h00A9);
    check("rst_lockup", lockup_err, 0);
    check("rst_period", period_pulse, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] mo;
    int         pc;
    int         pidx;
    logic [7:0] b0;
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus1.in_valid = 1'b0;
    bus1.din      = '0;
    bus1.out_ready = 1'b1;

    do_reset(2, 1'b0);

    // Directed first beat from the default seed.
    send(8'h00, 1'b1, 1'b1, 8'hC0, mo);
    drain();
    check("state_after_first", state_out, 15'h2903);

    // Random additive traffic with back-pressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) send(8'($urandom), 1'b1, 1'b0, 8'h00, mo);
    rdy_rand = 1'b0;
    rdy_hold = 1'b1;
    drain();

    // Full PRBS15 period on the 1-bit instance.
    pc   = 0;
    pidx = 0;
    @(negedge clk);
    bus1.din      = 1'b0;
    bus1.in_valid = 1'b1;
    for (int k = 1; k <= 32767; k++) begin
      @(negedge clk);
      #1;
      if (k == 32767) bus1.in_valid = 1'b0;
      model_step(hp, poly_v, 2'd0, 1, 8'h00, mo);
      check("prbs_bit", bus1.dout, mo[0]);
      if (p_pulse) begin
        pc++;
        pidx = k;
      end
    end
    check("period_count", pc, 1);
    check("period_index", pidx, 32767);
    check("period_state", p_state, 15'h00A9);
    check("period_lockup", p_lock, 0);

    // Multiplicative scramble then descramble with the same seed.
    load(15'h1234, 2'd1, 1'b1);
    rdy_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      orig[i] = 8'($urandom);
      send(orig[i], 1'b1, 1'b0, 8'h00, mo);
      scr[i] = mo;
    end
    rdy_rand = 1'b0;
    drain();
    load(15'h1234, 2'd2, 1'b0);
    rdy_rand = 1'b1;
    for (int i = 0; i < 30; i++) send(scr[i], 1'b1, 1'b1, orig[i], mo);
    rdy_rand = 1'b0;
    drain();

    // Descrambler with a mismatched seed resynchronises after 15 bits.
    load(15'h7ACE, 2'd2, 1'b0);
    for (int i = 0; i < 30; i++) send(scr[i], (i >= 2), 1'b1, orig[i], mo);
    drain();

    // Five stalled cycles with a pending beat.
    rdy_hold = 1'b0;
    send(8'($urandom), 1'b1, 1'b0, 8'h00, mo);
    @(negedge clk);
    bus.in_valid = 1'b1;
    b0 = 8'($urandom);
    bus.din = b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_dout", bus.dout, exp_q[0].dout);
      check("stall_state", state_out, exp_q[0].state);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rdy_hold = 1'b1;
    send(b0, 1'b1, 1'b0, 8'h00, mo);
    drain();

    // Zero-seed lock-up protection, sticky across later loads.
    load(15'h0000, 2'd0, 1'b0);
    check("lockup_set", lockup_err, 1);
    check("lockup_state", state_out, 15'h0001);
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b1, 1'b0, 8'h00, mo);
    drain();
    load(15'h1234, 2'd1, 1'b0);
    check("lockup_sticky", lockup_err, 1);
    check("reload_state", state_out, 15'h1234);
    load(15'h0000, 2'd2, 1'b0);
    check("zero_seed_mdsc", state_out, 15'h0000);
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b1, 1'b0, 8'h00, mo);
    drain();

    // seed_load discards a pending output.
    rdy_hold = 1'b0;
    send(8'($urandom), 1'b1, 1'b0, 8'h00, mo);
    load(15'h0F0F, 2'd0, 1'b1);
    rdy_hold = 1'b1;
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b1, 1'b0, 8'h00, mo);
    drain();

    // Reset mid-stream with a pending output.
    rdy_hold = 1'b0;
    send(8'($urandom), 1'b1, 1'b0, 8'h00, mo);
    do_reset(2, 1'b1);
    rdy_hold = 1'b1;
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b1, 1'b0, 8'h00, mo);
    drain();

    // Reserved mode behaves as additive, including zero-seed protection.
    load(15'h0000, 2'd3, 1'b0);
    check("mode3_lockup", lockup_err, 1);
    check("mode3_state", state_out, 15'h0001);
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b1, 1'b0, 8'h00, mo);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
